// File: rtl/rr_arbiter_lock.sv
// rr_arbiter_lock
//   Round-robin arbiter with a registered one-hot grant, optional grant
//   locking, and an optional limit on how long one owner may hold the grant.
//
// Parameters
//   NUM_REQ    number of requesters (>= 2)
//   IDX_W      width of the grant index
//   LOCK_MODE  0: re-arbitrate every cycle, 1: owner keeps grant while requesting
//   MAX_HOLD   LOCK_MODE=1 only; 0 = unlimited, M>0 = re-arbitrate after M cycles
//   HOLD_W     width of the hold counter
//
// Ports
//   clk        clock, rising edge
//   rstb       asynchronous active-low reset
//   enable     arbitration enable; low clears the grant, keeps the rotation pointer
//   req        request vector, bit i = requester i
//   gnt        registered one-hot grant (or zero)
//   gnt_valid  any grant bit set
//   gnt_idx    binary index of the granted requester, 0 when idle
module rr_arbiter_lock #(
  parameter int NUM_REQ   = 8,
  parameter int IDX_W     = $clog2(NUM_REQ),
  parameter int LOCK_MODE = 0,
  parameter int MAX_HOLD  = 0,
  parameter int HOLD_W    = $clog2(MAX_HOLD + 1) + 1
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx
);

  localparam logic [HOLD_W-1:0]  HOLD_LIM  = HOLD_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0]   PTR_RST   = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [IDX_W-1:0]   last_ptr;
  logic [HOLD_W-1:0]  hold_cnt;

  logic [IDX_W-1:0]   pick;
  logic               found;
  logic [IDX_W-1:0]   cand_idx;
  int                 cand;

  logic               keep;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic               valid_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic [IDX_W-1:0]   ptr_nxt;
  logic [HOLD_W-1:0]  hold_nxt;

  // Rotating search: candidates last_ptr+1 .. last_ptr+NUM_REQ, wrapped modulo
  // NUM_REQ (not 2^IDX_W). last_ptr itself is the final candidate so a sole
  // requester gets re-granted.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
  end

  always_comb begin
    gnt_nxt   = gnt;
    valid_nxt = gnt_valid;
    idx_nxt   = gnt_idx;
    ptr_nxt   = last_ptr;
    hold_nxt  = hold_cnt;
    keep      = (LOCK_MODE == 1) && gnt_valid && req[gnt_idx] &&
                ((MAX_HOLD == 0) || (hold_cnt < HOLD_LIM));

    if (!enable) begin
      gnt_nxt   = '0;
      valid_nxt = 1'b0;
      idx_nxt   = '0;
      hold_nxt  = '0;
    end else if (keep) begin
      // With a finite limit keep implies hold_cnt < MAX_HOLD, so only the
      // unlimited case can reach the counter's top value.
      if (hold_cnt != '1) hold_nxt = hold_cnt + HOLD_W'(1);
    end else if (found) begin
      gnt_nxt   = ONE_HOT_0 << pick;
      valid_nxt = 1'b1;
      idx_nxt   = pick;
      ptr_nxt   = pick;
      hold_nxt  = HOLD_W'(1);
    end else begin
      // Nobody requesting: go idle but remember the rotation position and hold count.
      gnt_nxt   = '0;
      valid_nxt = 1'b0;
      idx_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      last_ptr  <= PTR_RST;
      hold_cnt  <= '0;
    end else begin
      gnt       <= gnt_nxt;
      gnt_valid <= valid_nxt;
      gnt_idx   <= idx_nxt;
      last_ptr  <= ptr_nxt;
      hold_cnt  <= hold_nxt;
    end
  end

endmodule
